// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches over a request/ready
// handshake and buffers responses in a small prefetch FIFO for decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instructionAddress,
  output logic        instructionRequest,
  input  logic [31:0] instructionBus,
  input  logic        instructionReady,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        decodeStall,
  output logic [31:0] fetchInstr,
  output logic [31:0] fetchPC,
  output logic        fetchValid
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      pc_mem_q    [FIFO_DEPTH];

  logic accept;
  logic pop;
  logic push;

  // Handshake terms; request depends only on reset and registered count.
  assign instructionRequest = reset & (count_q != FULL_CNT);
  assign accept             = instructionRequest & instructionReady;
  assign fetchValid         = (count_q != '0);
  assign pop                = fetchValid & ~decodeStall;

  // Presented head entry; an empty FIFO shows a NOP at PC 0.
  assign instructionAddress = pc_q;
  assign fetchInstr         = fetchValid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign fetchPC            = fetchValid ? pc_mem_q[rd_ptr_q]    : 32'h0;

  // Next-state: redirect flushes and retargets, otherwise push/pop bookkeeping.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    if (redirect) begin
      pc_d     = redirectTarget;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        push     = 1'b1;
        pc_d     = pc_q + PC_STEP;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // PC, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage of {instruction, pc}; written at the write pointer on push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 32'h0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= instructionBus;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue-based model.
module tb_instruction_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] XK    = 32'hA500_0000;

  logic        clk;
  logic        reset;
  logic [31:0] instructionAddress;
  logic        instructionRequest;
  logic [31:0] instructionBus;
  logic        instructionReady;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        decodeStall;
  logic [31:0] fetchInstr;
  logic [31:0] fetchPC;
  logic        fetchValid;

  instruction_fetch_unit #(
    .RESET_PC  (RPC),
    .PC_STEP   (32'd1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .instructionAddress(instructionAddress),
    .instructionRequest(instructionRequest),
    .instructionBus    (instructionBus),
    .instructionReady  (instructionReady),
    .redirect          (redirect),
    .redirectTarget    (redirectTarget),
    .decodeStall       (decodeStall),
    .fetchInstr        (fetchInstr),
    .fetchPC           (fetchPC),
    .fetchValid        (fetchValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of fetched entries ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  task automatic model_reset();
    mq.delete();
    mpc = RPC;
  endtask

  task automatic model_edge(input logic rdy, input logic rd, input logic [31:0] tgt,
                            input logic st, input logic [31:0] bus);
    bit   req;
    bit   acc;
    bit   pp;
    ent_t dropped;
    req = (mq.size() < DEPTH);
    acc = req && rdy;
    pp  = (mq.size() > 0) && !st;
    if (rd) begin
      mq.delete();
      mpc = tgt;
    end else begin
      if (pp) dropped = mq.pop_front();
      if (acc) begin
        mq.push_back('{instr: bus, pc: mpc});
        mpc = mpc + 32'd1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    ev = (mq.size() != 0);
    chk({tag, " addr"},  instructionAddress, mpc);
    chk({tag, " req"},   32'(instructionRequest), 32'(mq.size() < DEPTH));
    chk({tag, " valid"}, 32'(fetchValid), 32'(ev));
    chk({tag, " instr"}, fetchInstr, ev ? mq[0].instr : 32'h0);
    chk({tag, " pc"},    fetchPC,    ev ? mq[0].pc    : 32'h0);
  endtask

  // Memory: correct word for the presented address when ready, garbage otherwise.
  task automatic drive(input logic rdy, input logic rd, input logic [31:0] tgt, input logic st);
    instructionReady = rdy;
    redirect         = rd;
    redirectTarget   = tgt;
    decodeStall      = st;
    instructionBus   = rdy ? (instructionAddress ^ XK) : $urandom();
  endtask

  // One model-checked cycle: compare, drive, clock, advance model.
  task automatic run_cycle(input string tag, input logic rdy, input logic rd,
                           input logic [31:0] tgt, input logic st);
    check_model(tag);
    drive(rdy, rd, tgt, st);
    @(posedge clk);
    model_edge(rdy, rd, tgt, st, instructionBus);
    #1;
  endtask

  // Hold reset low for three cycles, check reset values, release.
  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst addr",  instructionAddress, RPC);
    chk("rst req",   32'(instructionRequest), 32'd0);
    chk("rst valid", 32'(fetchValid), 32'd0);
    chk("rst instr", fetchInstr, 32'h0);
    chk("rst pc",    fetchPC, 32'h0);
    reset = 1'b1;
    #1;
    chk("release req", 32'(instructionRequest), 32'd1);
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] e_addr;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rdy, logic redir, logic [31:0] tgt, logic stall,
                              logic [31:0] a, logic rq, logic vl, logic [31:0] p);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.tgt = tgt; r.stall = stall;
    r.e_addr = a; r.e_req = rq; r.e_valid = vl; r.e_pc = p;
    return r;
  endfunction

  initial begin
    // expected outputs of the cycle, then inputs applied for that cycle
    tbl[0]  = mk(1, 0, 0, 1, 32'h100, 1, 0, 32'h0);   // stall from release
    tbl[1]  = mk(1, 0, 0, 1, 32'h101, 1, 1, 32'h100);
    tbl[2]  = mk(1, 0, 0, 1, 32'h102, 0, 1, 32'h100); // full: no request
    tbl[3]  = mk(1, 0, 0, 0, 32'h102, 0, 1, 32'h100); // drop stall
    tbl[4]  = mk(1, 0, 0, 0, 32'h102, 1, 1, 32'h101);
    tbl[5]  = mk(1, 0, 0, 0, 32'h103, 1, 1, 32'h102);
    tbl[6]  = mk(0, 0, 0, 0, 32'h104, 1, 1, 32'h103);
    tbl[7]  = mk(0, 0, 0, 0, 32'h104, 1, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 0, 32'h104, 1, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 0, 32'h105, 1, 1, 32'h104);
    tbl[10] = mk(0, 0, 0, 0, 32'h105, 1, 0, 32'h0);
    tbl[11] = mk(1, 0, 0, 0, 32'h105, 1, 0, 32'h0);
    tbl[12] = mk(1, 0, 0, 1, 32'h106, 1, 1, 32'h105);
    tbl[13] = mk(1, 1, 32'h40, 0, 32'h107, 0, 1, 32'h105);        // redirect, full
    tbl[14] = mk(1, 0, 0, 0, 32'h40, 1, 0, 32'h0);
    tbl[15] = mk(1, 1, 32'hFFFF_FFFF, 0, 32'h41, 1, 1, 32'h40);   // redirect, accept dropped
    tbl[16] = mk(1, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 32'h0);
    tbl[17] = mk(1, 0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFF);         // PC wrapped
    tbl[18] = mk(0, 0, 0, 0, 32'h1, 1, 1, 32'h0);
    tbl[19] = mk(0, 0, 0, 0, 32'h1, 1, 0, 32'h0);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    instructionReady = 1'b0;
    redirect = 1'b0;
    redirectTarget = 32'h0;
    decodeStall = 1'b0;
    instructionBus = 32'h0;
    #2;
    do_reset();

    // Directed table: stall fill/drain, bubbles, redirects and wrap.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d addr", i),  instructionAddress, tbl[i].e_addr);
      chk($sformatf("v%0d req", i),   32'(instructionRequest), 32'(tbl[i].e_req));
      chk($sformatf("v%0d valid", i), 32'(fetchValid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d pc", i),    fetchPC, tbl[i].e_pc);
      chk($sformatf("v%0d instr", i), fetchInstr, tbl[i].e_valid ? (tbl[i].e_pc ^ XK) : 32'h0);
      drive(tbl[i].rdy, tbl[i].redir, tbl[i].tgt, tbl[i].stall);
      @(posedge clk);
      #1;
    end

    // Streaming after reset: one instruction per cycle.
    do_reset();
    for (int i = 0; i < 40; i++) run_cycle("stream", 1'b1, 1'b0, 32'h0, 1'b0);

    // Wait states: ready every third cycle.
    do_reset();
    for (int i = 0; i < 300; i++)
      run_cycle("wait3", (i % 3) == 2, 1'b0, 32'h0, ($urandom_range(0, 3) == 0));

    // Randomized mix of ready, stall and redirect.
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      int unsigned rp;
      int unsigned sp;
      rp = $urandom_range(10, 100);
      sp = $urandom_range(0, 70);
      for (int i = 0; i < 150; i++) begin
        logic        rd;
        logic [31:0] tg;
        rd = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0:       tg = 32'hFFFF_FFFF;
          1:       tg = 32'hFFFF_FFFE;
          default: tg = $urandom();
        endcase
        run_cycle("rand", ($urandom_range(1, 100) <= rp), rd, tg,
                  ($urandom_range(1, 100) <= sp));
      end
    end

    // Async reset mid-operation with two entries buffered.
    do_reset();
    run_cycle("prefill", 1'b1, 1'b0, 32'h0, 1'b1);
    run_cycle("prefill", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("prefill count", 32'(mq.size()), 32'd2);
    check_model("full");
    #2;
    reset = 1'b0;
    #1;
    chk("async addr",  instructionAddress, RPC);
    chk("async req",   32'(instructionRequest), 32'd0);
    chk("async valid", 32'(fetchValid), 32'd0);
    chk("async instr", fetchInstr, 32'h0);
    chk("async pc",    fetchPC, 32'h0);
    do_reset();
    for (int i = 0; i < 20; i++) run_cycle("restart", 1'b1, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage of the pipelined processor. It owns the program counter and issues word fetches to instruction memory over a request/ready handshake. Fetched words are buffered in a small prefetch FIFO, and the FIFO head is presented to the decode stage together with its PC. A redirect from execute (taken jump) flushes the buffer and restarts fetch at the jump target. A stall (bubble) from decode holds the presented instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 1, PC increment per instruction (word addressing). Sum is modulo 2^32.
- FIFO_DEPTH, 2, prefetch entries. Power of two, 2..8.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low. Low clears all state immediately, with no clock edge needed.
- instructionAddress  out  32  address of the current fetch request (the PC register).
- instructionRequest  out  1  fetch request.
- instructionBus  in  32  instruction word. Valid when instructionReady=1.
- instructionReady  in  1  memory response for the current instructionAddress.
- redirect  in  1  taken/missed jump from execute. Single-cycle pulse.
- redirectTarget  in  32  new PC. Sampled when redirect=1.
- decodeStall  in  1  decode cannot accept this cycle (bubble).
- fetchInstr  out  32  FIFO head instruction. 0 when empty.
- fetchPC  out  32  PC of fetchInstr. 0 when empty.
- fetchValid  out  1  FIFO non-empty.

## Operation
- State: pc; FIFO storage of {instr, pc} × FIFO_DEPTH; read and write pointers; count (0..FIFO_DEPTH).
- instructionRequest = reset & (count != FIFO_DEPTH). It depends on registered state only, so there is no combinational path from decodeStall or redirect.
- accept = instructionRequest & instructionReady, sampled at posedge.
- Memory contract: memory may change or abort a response whenever instructionAddress changes. Ready always refers to the address presented in that same cycle.
- pop = fetchValid & ~decodeStall.
- Normal edge (no redirect):
  - On accept: push {instructionBus, pc} and set pc <= pc + PC_STEP.
  - On pop: advance the read pointer.
  - Push and pop in the same cycle leave count unchanged.
- Redirect edge (highest priority):
  - pc <= redirectTarget; count, read pointer and write pointer <= 0.
  - Any accept in that cycle is discarded, and pc does not increment.
  - A pop in that cycle is irrelevant: the entry is wrong-path and flushed.
- Full (count == FIFO_DEPTH): no request. pc and instructionAddress hold.
- Empty: fetchValid=0, fetchInstr=0 (NOP), fetchPC=0. decodeStall is ignored.
- PC wraps 32'hFFFF_FFFF + 1 -> 32'h0000_0000 with no flag.
- No FSM beyond the FIFO count. Overflow is impossible because no push is made when full. Underflow is impossible because pop requires fetchValid.

## Timing
- Reset (reset=0) values: instructionAddress=RESET_PC, instructionRequest=0, fetchValid=0, fetchInstr=0, fetchPC=0, count=0.
- First request: instructionRequest goes high in the cycle reset releases. It is combinational from reset and the empty count.
- Fetch latency: a word accepted at edge N appears on fetchInstr/fetchValid in cycle N+1.
- Throughput: 1 instruction/cycle with zero-wait memory (ready=1 every cycle) and no stall.
- Redirect at edge N:
  - Cycle N+1: instructionAddress=redirectTarget and fetchValid=0.
  - Earliest valid target instruction: cycle N+2.
- Stall: fetchInstr and fetchPC are held stable for every cycle that decodeStall=1 and fetchValid=1.
- Reset assertion mid-operation: all outputs take their reset values asynchronously. FIFO contents are discarded.

## Test plan
1. **Reset.** RESET_PC=0x100; hold reset=0 for 3 cycles. Required: address 0x100, request 0, fetchValid 0, fetchInstr 0. Release reset: request=1 in the same cycle.
2. **Streaming.** ready=1 always; instructionBus = address ^ 0xA500_0000; decodeStall=0. Required: fetchValid from the cycle after the first accept; fetchPC = 0x100, 0x101, 0x102… one per cycle; each fetchInstr matches its PC.
3. **Stall fill and drain.**
   - decodeStall=1 from reset release. Required: exactly 2 accepts, then request=0 and address held at 0x102; fetchPC stays at 0x100.
   - Drop the stall. Required: PCs 0x100, 0x101, 0x102… with no loss or duplication.
4. **Wait states.** ready=1 every third cycle. Required: address held until accepted; each PC delivered exactly once, in order.
5. **Redirect with a full FIFO and ready=1 on the same edge.** redirect with target 0x40. Required: next cycle fetchValid=0 and address 0x40; the simultaneous response is discarded; first valid fetchPC=0x40. Second case: redirect to 0xFFFF_FFFF. Required: the following fetch address is 0x0000_0000.
6. **Async reset mid-operation.** Assert reset between clock edges with count=2. Required: fetchValid=0 and address=RESET_PC before the next posedge; normal restart after release.
